sm4_decrypt_iter: RTL and testbench
===================================

Name: sm4_decrypt_iter

Overview:
Iterative SM4 decryption engine. It is the receive-side counterpart of the pipelined SM4 encryptor and uses the same key-load and AXI-Stream-style data ports. It expands the 128-bit key into 32 round keys (one per cycle, stored in a register file), then decrypts one 128-bit block per 33 cycles by applying the round keys in reverse order (rk31 down to rk0). It trades throughput for area.

Parameters:
P_INITIAL_KEY, 128'h000102030405060708090A0B0C0D0E0F, key expanded automatically after reset.

Ports:
i_clk  input  1  single clock; all state changes on the rising edge
i_rst  input  1  asynchronous, active-high reset
i_Initial_Key  input  128  new master key MK
i_Initial_valid  input  1  one-cycle pulse: load i_Initial_Key and restart key expansion
i_axis_data  input  128  ciphertext block, {X0,X1,X2,X3}, X0 = MSW
i_axis_valid  input  1  ciphertext valid
o_axis_ready  output  1  engine can accept a block
o_axim_data  output  128  plaintext {Y0..Y3}; holds its value until the next result
o_axim_valid  output  1  one-cycle pulse per block; no backpressure

Behaviour:
- Reset values:
  - o_axis_ready=0, o_axim_valid=0, o_axim_data=0
  - rk file = 0, key register = P_INITIAL_KEY
  - FSM = KEYEXP with cnt=0
  - the first edge after reset release begins expansion of P_INITIAL_KEY.
- FSM states: KEYEXP, IDLE, ROUND.
- KEYEXP:
  - On entry, K[0..3] = MK ^ FK.
  - Each cycle i (cnt 0..31): rk[i] = K0 ^ T'(K1^K2^K3^CK[i]); K shifts to {K1,K2,K3,rk[i]}.
  - At cnt=31: go to IDLE and set o_axis_ready=1 on the same edge.
  - From load to ready is 32 edges.
- IDLE:
  - o_axis_ready=1.
  - On the edge where i_axis_valid & o_axis_ready: latch the block into X, clear o_axis_ready, cnt=0, go to ROUND.
- ROUND:
  - Each edge computes X = {X1,X2,X3, X0 ^ T(X1^X2^X3^rk[31-cnt])}.
  - On the edge at cnt=31, the round result goes straight into o_axim_data in reversed word order {X35,X34,X33,X32}.
  - On that same edge: o_axim_valid=1 for one cycle, o_axis_ready=1, go to IDLE.
- Latency and throughput:
  - Acceptance edge E; o_axim_valid is high in the cycle after edge E+32.
  - Earliest next acceptance is edge E+33, giving 33 cycles per block.
- T / T':
  - tau = byte-wise SBOX on the 32-bit word.
  - L(B) = B^(B<<<2)^(B<<<10)^(B<<<18)^(B<<<24).
  - L'(B) = B^(B<<<13)^(B<<<23).
  - All arithmetic is 32-bit XOR/rotate; there is no carry anywhere.
- i_Initial_valid in any state, including mid-ROUND or mid-KEYEXP:
  - Next edge: latch i_Initial_Key, o_axis_ready=0, cnt=0, go to KEYEXP.
  - Any in-flight block is discarded and produces no o_axim_valid.
  - o_axim_data keeps its last value.
- i_Initial_valid and an i_axis handshake in the same cycle: the key load wins and the block is not accepted. Because ready drops, the source must re-present the block.
- i_Initial_valid held for several cycles: expansion restarts on every asserted cycle; it completes 32 edges after the last assertion.
- i_axis_valid while o_axis_ready=0: ignored; the data is not sampled.
- Asynchronous reset mid-ROUND: all outputs return to their reset values immediately; the engine re-expands P_INITIAL_KEY, not the last loaded key.
- The rk file is written only in KEYEXP and is read only when cnt is in 0..31, so no out-of-range index occurs.

Decomposition:
- sm4_pkg holds:
  - SBOX[256] constant, FK[4], CK[32]
  - functions sm4_tau, sm4_l, sm4_l_key
  - state enum {KEYEXP, IDLE, ROUND}
  - This package is shared with the encryptor's round and key blocks.
- One sub-module: sm4_t_transform.
  - Inputs: 32-bit input, i_key_mode select.
  - Purely combinational: tau followed by L or L'.
  - Instantiated twice, once for the key path and once for the data path. Alternatively, one muxed instance, since KEYEXP and ROUND never overlap.

Test Plan:
- Reset release with no stimulus → o_axis_ready low for exactly 32 cycles, then high; o_axim_valid stays 0 throughout.
- Standard vector → o_axim_data=0123456789ABCDEFFEDCBA9876543210, o_axim_valid 32 cycles after acceptance.
  - Key load: i_Initial_Key=0123456789ABCDEFFEDCBA9876543210 pulse.
  - After ready: send 681EDF34D206965E86B3E94F536E4246.
- Back-to-back: i_axis_valid held high with 4 different ciphertexts from the encryptor under the default key → one block every 33 cycles; all 4 plaintexts recovered in order.
- i_Initial_valid pulsed at round 15 of a block → no o_axim_valid for that block; ready returns 32 cycles later; the re-sent block decrypts correctly under the new key.
- Simultaneous i_Initial_valid and accepted-looking handshake → block dropped; ready=0 next cycle.
- Asynchronous reset at round 20 → outputs 0 immediately; the next decryption uses P_INITIAL_KEY; round-trip with the encryptor (same default key) matches for 100 random blocks.

Source files
------------

// File: rtl/sm4_pkg.sv
// SM4 constants, T-transform helper functions and the engine state encoding.
// Shared between the iterative decryptor and the encryptor's round/key blocks.
package sm4_pkg;

    typedef enum logic [1:0] {KEYEXP, IDLE, ROUND} sm4_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [31:0] CK [32] = '{
        32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
        32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
        32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
        32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
        32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
        32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
        32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
        32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
    };

    function automatic logic [31:0] sm4_tau(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    function automatic logic [31:0] sm4_l_key(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_t_transform.sv
// Combinational SM4 T transform: byte-wise S-box followed by the data (L)
// or key-schedule (L') linear layer.
module sm4_t_transform
    import sm4_pkg::*;
(
    input  logic [31:0] word,
    input  logic        i_key_mode,
    output logic [31:0] result
);

    logic [31:0] subst;

    assign subst  = sm4_tau(word);
    assign result = i_key_mode ? sm4_l_key(subst) : sm4_l(subst);

endmodule

// File: rtl/sm4_decrypt_iter.sv
// Iterative SM4 decryptor: 32-cycle key expansion into a round-key file, then
// one round per cycle using the round keys in reverse order.
module sm4_decrypt_iter
    import sm4_pkg::*;
#(
    parameter logic [127:0] P_INITIAL_KEY = 128'h000102030405060708090A0B0C0D0E0F
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_Initial_Key,
    input  logic         i_Initial_valid,
    input  logic [127:0] i_axis_data,
    input  logic         i_axis_valid,
    output logic         o_axis_ready,
    output logic [127:0] o_axim_data,
    output logic         o_axim_valid
);

    sm4_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] k  [4];
    logic [31:0] x  [4];
    logic [31:0] rk [32];

    logic        key_mode;
    logic [31:0] t_in;
    logic [31:0] t_out;
    logic [31:0] rk_new;
    logic [31:0] x_new;

    // One shared T instance: key expansion and rounds never run together.
    always_comb begin
        key_mode = (state == KEYEXP);
        t_in     = 32'h0;
        if (key_mode) t_in = k[1] ^ k[2] ^ k[3] ^ CK[cnt];
        else          t_in = x[1] ^ x[2] ^ x[3] ^ rk[~cnt];
        rk_new   = k[0] ^ t_out;
        x_new    = x[0] ^ t_out;
    end

    sm4_t_transform u_t (
        .word       (t_in),
        .i_key_mode (key_mode),
        .result     (t_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= KEYEXP;
            cnt          <= 5'd0;
            o_axis_ready <= 1'b0;
            o_axim_valid <= 1'b0;
            o_axim_data  <= '0;
            for (int j = 0; j < 4; j++) begin
                k[j] <= P_INITIAL_KEY[127-32*j -: 32] ^ FK[j];
                x[j] <= 32'h0;
            end
            for (int j = 0; j < 32; j++) rk[j] <= 32'h0;
        end else begin
            o_axim_valid <= 1'b0;
            if (i_Initial_valid) begin
                // A key load preempts everything, including a block in flight.
                for (int j = 0; j < 4; j++) k[j] <= i_Initial_Key[127-32*j -: 32] ^ FK[j];
                cnt          <= 5'd0;
                o_axis_ready <= 1'b0;
                state        <= KEYEXP;
            end else begin
                case (state)
                    KEYEXP: begin
                        rk[cnt] <= rk_new;
                        k[0]    <= k[1];
                        k[1]    <= k[2];
                        k[2]    <= k[3];
                        k[3]    <= rk_new;
                        cnt     <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state        <= IDLE;
                            o_axis_ready <= 1'b1;
                        end
                    end
                    IDLE: begin
                        if (i_axis_valid && o_axis_ready) begin
                            for (int j = 0; j < 4; j++) x[j] <= i_axis_data[127-32*j -: 32];
                            cnt          <= 5'd0;
                            o_axis_ready <= 1'b0;
                            state        <= ROUND;
                        end
                    end
                    ROUND: begin
                        x[0] <= x[1];
                        x[1] <= x[2];
                        x[2] <= x[3];
                        x[3] <= x_new;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            o_axim_data  <= {x_new, x[3], x[2], x[1]};
                            o_axim_valid <= 1'b1;
                            o_axis_ready <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: begin
                        cnt          <= 5'd0;
                        o_axis_ready <= 1'b0;
                        state        <= KEYEXP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm4_decrypt_iter.sv
// Directed bench for sm4_decrypt_iter; expected plaintexts come from the
// published SM4 vector and a forward-direction SM4 encryption model.
module tb_sm4_decrypt_iter;
    import sm4_pkg::SBOX;

    localparam logic [127:0] KEY_DEF = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEY_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT_STD  = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [127:0] PT_STD  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [31:0]  FK_M [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic [127:0] i_Initial_Key = '0;
    logic         i_Initial_valid = 1'b0;
    logic [127:0] i_axis_data = '0;
    logic         i_axis_valid = 1'b0;
    logic         o_axis_ready;
    logic [127:0] o_axim_data;
    logic         o_axim_valid;

    int checks = 0;
    int failures = 0;

    sm4_decrypt_iter dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_Initial_Key   (i_Initial_Key),
        .i_Initial_valid (i_Initial_valid),
        .i_axis_data     (i_axis_data),
        .i_axis_valid    (i_axis_valid),
        .o_axis_ready    (o_axis_ready),
        .o_axim_data     (o_axim_data),
        .o_axim_valid    (o_axim_valid)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] rotl_m(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau_m(input logic [31:0] w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = SBOX[w[8*j +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] ck_m(input int i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
        return r;
    endfunction

    function automatic logic [127:0] enc_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] kk [36];
        logic [31:0] rkm [32];
        logic [31:0] xx [36];
        logic [31:0] b;
        for (int j = 0; j < 4; j++) begin
            kk[j] = key[127-32*j -: 32] ^ FK_M[j];
            xx[j] = pt[127-32*j -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            b = tau_m(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck_m(i));
            kk[i+4] = kk[i] ^ b ^ rotl_m(b, 13) ^ rotl_m(b, 23);
            rkm[i] = kk[i+4];
        end
        for (int i = 0; i < 32; i++) begin
            b = tau_m(xx[i+1] ^ xx[i+2] ^ xx[i+3] ^ rkm[i]);
            xx[i+4] = xx[i] ^ b ^ rotl_m(b, 2) ^ rotl_m(b, 10) ^ rotl_m(b, 18) ^ rotl_m(b, 24);
        end
        return {xx[35], xx[34], xx[33], xx[32]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ready(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (!o_axis_ready && n < 200) begin
            step();
            n++;
            if (o_axim_valid) saw_valid = 1'b1;
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_axim_valid && n < 200);
    endtask

    task automatic load_key(input logic [127:0] key);
        i_Initial_Key   = key;
        i_Initial_valid = 1'b1;
        step();
        i_Initial_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] ct);
        i_axis_data  = ct;
        i_axis_valid = 1'b1;
        step();
        i_axis_valid = 1'b0;
    endtask

    logic [127:0] pts [4];
    logic [127:0] cts [4];
    int           acc_t [4];
    logic [127:0] pt, ct;
    int           n, cyc, na, no;
    logic         saw, rb;

    initial begin
        // Reset values
        #2 i_rst = 1'b1;
        #2;
        check("rst_ready", {127'b0, o_axis_ready}, 128'd0);
        check("rst_valid", {127'b0, o_axim_valid}, 128'd0);
        check("rst_data", o_axim_data, 128'd0);
        step();
        step();
        i_rst = 1'b0;

        // Automatic expansion of the default key after reset release
        wait_ready(n, saw);
        check("boot_ready_latency", 128'(n), 128'd32);
        check("boot_no_valid", {127'b0, saw}, 128'd0);

        // Published standard vector
        load_key(KEY_STD);
        check("load_ready_low", {127'b0, o_axis_ready}, 128'd0);
        wait_ready(n, saw);
        check("load_ready_latency", 128'(n), 128'd32);
        send_block(CT_STD);
        check("accept_ready_low", {127'b0, o_axis_ready}, 128'd0);
        wait_out(n);
        check("std_latency", 128'(n), 128'd32);
        check("std_plaintext", o_axim_data, PT_STD);
        check("std_ready_back", {127'b0, o_axis_ready}, 128'd1);
        step();
        check("std_valid_pulse", {127'b0, o_axim_valid}, 128'd0);
        check("std_data_hold", o_axim_data, PT_STD);

        // Back-to-back blocks under the default key, i_axis_valid held high
        load_key(KEY_DEF);
        wait_ready(n, saw);
        pts[0] = 128'h00112233445566778899AABBCCDDEEFF;
        pts[1] = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
        pts[2] = 128'h0;
        pts[3] = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
        for (int i = 0; i < 4; i++) cts[i] = enc_model(KEY_DEF, pts[i]);
        i_axis_data  = cts[0];
        i_axis_valid = 1'b1;
        cyc = 0; na = 0; no = 0;
        while (no < 4 && cyc < 500) begin
            rb = o_axis_ready;
            step();
            cyc++;
            if (rb && i_axis_valid) begin
                acc_t[na] = cyc;
                na++;
                if (na < 4) i_axis_data = cts[na];
                else i_axis_valid = 1'b0;
            end
            if (o_axim_valid) begin
                check($sformatf("b2b_pt%0d", no), o_axim_data, pts[no]);
                no++;
            end
        end
        i_axis_valid = 1'b0;
        check("b2b_count", 128'(no), 128'd4);
        for (int i = 1; i < 4; i++)
            if (i < na) check($sformatf("b2b_interval%0d", i), 128'(acc_t[i] - acc_t[i-1]), 128'd33);

        // Key load in the middle of a block
        send_block(enc_model(KEY_DEF, 128'h11111111222222223333333344444444));
        repeat (15) step();
        load_key(KEY_STD);
        wait_ready(n, saw);
        check("midkey_no_valid", {127'b0, saw}, 128'd0);
        check("midkey_ready_latency", 128'(n), 128'd32);
        check("midkey_data_hold", o_axim_data, pts[3]);
        pt = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        send_block(enc_model(KEY_STD, pt));
        wait_out(n);
        check("midkey_resend", o_axim_data, pt);

        // Key load and handshake in the same cycle: key wins, block dropped
        i_axis_data     = CT_STD;
        i_axis_valid    = 1'b1;
        i_Initial_Key   = KEY_DEF;
        i_Initial_valid = 1'b1;
        step();
        i_axis_valid    = 1'b0;
        i_Initial_valid = 1'b0;
        check("collide_ready_low", {127'b0, o_axis_ready}, 128'd0);
        wait_ready(n, saw);
        check("collide_no_valid", {127'b0, saw}, 128'd0);
        check("collide_ready_latency", 128'(n), 128'd32);

        // Asynchronous reset at round 20, with a non-default key loaded
        load_key(KEY_STD);
        wait_ready(n, saw);
        send_block(CT_STD);
        repeat (20) step();
        #2 i_rst = 1'b1;
        #1;
        check("arst_ready", {127'b0, o_axis_ready}, 128'd0);
        check("arst_valid", {127'b0, o_axim_valid}, 128'd0);
        check("arst_data", o_axim_data, 128'd0);
        step();
        step();
        i_rst = 1'b0;
        wait_ready(n, saw);
        check("arst_ready_latency", 128'(n), 128'd32);

        // Random round-trips under the reset key
        for (int i = 0; i < 100; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = enc_model(KEY_DEF, pt);
            send_block(ct);
            wait_out(n);
            check($sformatf("rand_latency%0d", i), 128'(n), 128'd32);
            check($sformatf("rand_pt%0d", i), o_axim_data, pt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
